// File: rtl/data_mem_block_mover.sv
// data_mem_block_mover
// Block-transfer master for the single-port data memory. A start pulse
// either copies len words from src_addr to dst_addr, one read and one write
// per word, or fills dst_addr with a constant at one write per cycle.
// Pointers wrap modulo 2^ADDR_W. Every output is decoded from registered
// state, so there is no combinational path from mem_out to any output.

module data_mem_block_mover #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [15:0]       len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_done,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_mode;        // 0 = copy, 1 = fill
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [15:0]       r_remaining;
    logic [DATA_W-1:0] r_fill_value;
    logic [DATA_W-1:0] r_buf;         // word read in RD, written in the following WR
    logic [15:0]       r_words_done;

    // State register; reset abandons any transfer in flight without a done pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: copy alternates RD/WR per word, fill stays in WR.
    // NOTE: the default assignment first means every path assigns the
    // signal, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == 16'd0) begin
                        w_next_state = S_DONE;
                    end else if (mode) begin
                        w_next_state = S_WR;
                    end else begin
                        w_next_state = S_RD;
                    end
                end
            end
            S_RD: begin
                w_next_state = S_WR;
            end
            S_WR: begin
                if (r_remaining == 16'd1) begin
                    w_next_state = S_DONE;
                end else if (r_mode) begin
                    w_next_state = S_WR;
                end else begin
                    w_next_state = S_RD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Transfer datapath: capture the request in IDLE, latch read data in RD,
    // advance the pointers and counters after each committed write in WR.
    // NOTE: the buffer and the captured operands are reset as well, because
    // they feed outputs and must not carry stale values after a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode       <= 1'b0;
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_remaining  <= '0;
            r_fill_value <= '0;
            r_buf        <= '0;
            r_words_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode       <= mode;
                        r_src_ptr    <= src_addr;
                        r_dst_ptr    <= dst_addr;
                        r_remaining  <= len;
                        r_fill_value <= fill_value;
                        r_words_done <= '0;
                    end
                end
                S_RD: begin
                    r_buf <= mem_out;
                end
                S_WR: begin
                    r_src_ptr    <= r_src_ptr + ADDR_W'(1);
                    r_dst_ptr    <= r_dst_ptr + ADDR_W'(1);
                    r_remaining  <= r_remaining - 16'd1;
                    r_words_done <= r_words_done + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state; memory outputs are idle outside RD/WR.
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        mem_access_addr = '0;
        mem_in          = '0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        case (r_state)
            S_RD: begin
                busy            = 1'b1;
                mem_access_addr = r_src_ptr;
                mem_read_en     = 1'b1;
            end
            S_WR: begin
                busy            = 1'b1;
                mem_access_addr = r_dst_ptr;
                mem_write_en    = 1'b1;
                mem_in          = r_mode ? r_fill_value : r_buf;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign words_done = r_words_done;

endmodule

// File: tb/tb_data_mem_block_mover.sv
// Testbench for data_mem_block_mover: a 64K-word memory model, a table of
// directed transfers, randomized transfers checked against a word-level
// reference image, and a hand-written reset-mid-transfer sequence.

module tb_data_mem_block_mover;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_in;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [15:0] mem_out;

    bit   [15:0] mem  [0:65535];   // memory seen by the DUT
    bit   [15:0] refm [0:65535];   // expected memory image

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_busy  = 0;
    int          n_rd    = 0;
    int          n_conf  = 0;
    int          n_done  = 0;
    logic [15:0] wq [$];           // addresses of committed writes, in order

    typedef struct {
        bit        mode;
        bit [15:0] src;
        bit [15:0] dst;
        bit [15:0] len;
        bit [15:0] fill;
        int        exp_edges;      // done is high in the cycle after E(exp_edges)
        bit [15:0] pre_base;
        int        pre_cnt;
        bit [15:0] pre_val;
    } vec_t;

    data_mem_block_mover #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mode            (mode),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .len             (len),
        .fill_value      (fill_value),
        .busy            (busy),
        .done            (done),
        .words_done      (words_done),
        .mem_access_addr (mem_access_addr),
        .mem_in          (mem_in),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_out         (mem_out)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write commits at the rising edge.
    assign mem_out = mem[mem_access_addr];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_access_addr] <= mem_in;
            wq.push_back(mem_access_addr);
        end
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy) n_busy++;
        if (mem_read_en) n_rd++;
        if (mem_read_en && mem_write_en) n_conf++;
        if (done) n_done++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input bit [15:0] a, input bit [15:0] d);
        mem[a]  = d;
        refm[a] = d;
    endtask

    // Reference: ascending word-by-word copy on the expected image, so an
    // overlapping copy naturally re-reads words it has already written.
    task automatic ref_xfer(input bit m, input bit [15:0] s, input bit [15:0] d,
                            input bit [15:0] n, input bit [15:0] f);
        bit [15:0] sa;
        bit [15:0] da;
        for (int k = 0; k < int'(n); k++) begin
            sa = s + 16'(k);
            da = d + 16'(k);
            refm[da] = m ? f : refm[sa];
        end
    endtask

    function automatic int image_mismatches();
        int cnt = 0;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] != refm[i]) cnt++;
        end
        return cnt;
    endfunction

    task automatic run_xfer(input vec_t v, input string tag);
        int        e;
        bit        found;
        int        budget;
        int        b0, r0, c0, d0, w0, bad, n;
        bit [15:0] exp_a;
        n = int'(v.len);
        for (int i = 0; i < v.pre_cnt; i++) load(v.pre_base + 16'(i), v.pre_val + 16'(i));
        ref_xfer(v.mode, v.src, v.dst, v.len, v.fill);
        b0 = n_busy; r0 = n_rd; c0 = n_conf; d0 = n_done; w0 = wq.size();

        @(negedge clk);
        mode = v.mode; src_addr = v.src; dst_addr = v.dst; len = v.len;
        fill_value = v.fill; start = 1'b1;
        @(posedge clk);                                  // E0
        #1;
        start = 1'b0;
        // Captured operands must be insensitive to later input changes.
        mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
        len = 16'($urandom); fill_value = 16'($urandom);

        e = 0; found = 1'b0; budget = 2 * n + 8;
        while (!found && e <= budget) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
            end else begin
                start = (e == 1) && busy;                // stray start while busy
                @(posedge clk);
                e++;
            end
        end
        start = 1'b0;
        check({tag, ".done_seen"}, int'(found), 1);
        check({tag, ".done_edge"}, e, v.exp_edges);
        check({tag, ".words_done"}, int'(words_done), n);

        @(negedge clk);
        #1;
        check({tag, ".done_one_cycle"}, int'({done, busy}), 0);
        check({tag, ".busy_cycles"}, n_busy - b0, v.mode ? n : 2 * n);
        check({tag, ".read_cycles"}, n_rd - r0, v.mode ? 0 : n);
        check({tag, ".rd_wr_overlap"}, n_conf - c0, 0);
        check({tag, ".done_pulses"}, n_done - d0, 1);
        check({tag, ".write_count"}, wq.size() - w0, n);
        bad = 0;
        for (int k = 0; k < n && (w0 + k) < wq.size(); k++) begin
            exp_a = v.dst + 16'(k);
            if (wq[w0 + k] != exp_a) bad++;
        end
        check({tag, ".write_order"}, bad, 0);
        check({tag, ".mem_image"}, image_mismatches(), 0);
    endtask

    vec_t vecs [7];
    vec_t rv;
    int   d0;

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_value = '0;

        // Background contents at both ends of the address space.
        for (int i = 0; i < 1024; i++) load(16'(i), 16'($urandom));
        for (int i = 65280; i < 65536; i++) load(16'(i), 16'($urandom));

        //            mode  src      dst      len    fill     edges pre_base pre_cnt pre_val
        vecs[0] = '{1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0000, 8, 16'h0010, 4, 16'hA001};
        vecs[1] = '{1'b1, 16'h0000, 16'h0020, 16'd3, 16'h5A5A, 3, 16'h0020, 4, 16'h7700};
        vecs[2] = '{1'b0, 16'h0030, 16'h0050, 16'd0, 16'h0000, 0, 16'h0030, 0, 16'h0000};
        vecs[3] = '{1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'hC3C3, 4, 16'hFFFC, 8, 16'h1000};
        vecs[4] = '{1'b0, 16'h0010, 16'h0011, 16'd3, 16'h0000, 6, 16'h0010, 1, 16'h1111};
        vecs[5] = '{1'b0, 16'h0080, 16'h0090, 16'd1, 16'h0000, 2, 16'h0080, 1, 16'hBEEF};
        vecs[6] = '{1'b1, 16'h0000, 16'h0095, 16'd1, 16'h9696, 1, 16'h0094, 3, 16'h0300};

        #1;
        check("reset.outputs_zero",
              $countones({busy, done, words_done, mem_access_addr, mem_in,
                          mem_write_en, mem_read_en}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle.outputs_zero",
              $countones({busy, done, words_done, mem_access_addr, mem_in,
                          mem_write_en, mem_read_en}), 0);

        for (int i = 0; i < 7; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Literal spot checks of the directed cases.
        check("copy.mem40", int'(mem[16'h0040]), 'hA001);
        check("copy.mem43", int'(mem[16'h0043]), 'hA004);
        check("fill.mem22", int'(mem[16'h0022]), 'h5A5A);
        check("fill.mem23_kept", int'(mem[16'h0023]), 'h7703);
        check("wrap.mem0000", int'(mem[16'h0000]), 'hC3C3);
        check("wrap.mem0002_kept", int'(mem[16'h0002]), int'(refm[16'h0002]));
        check("overlap.mem13", int'(mem[16'h0013]), 'h1111);

        // Randomized transfers in a small window so copies often overlap.
        for (int i = 0; i < 10; i++) begin
            rv.mode = 1'($urandom);
            rv.src = 16'($urandom_range(0, 63));
            rv.dst = 16'($urandom_range(0, 63));
            rv.len = 16'($urandom_range(0, 8));
            rv.fill = 16'($urandom);
            rv.exp_edges = rv.mode ? int'(rv.len) : 2 * int'(rv.len);
            rv.pre_base = 16'h0; rv.pre_cnt = 0; rv.pre_val = 16'h0;
            run_xfer(rv, $sformatf("rnd%0d", i));
        end

        // Reset during the WR of word 2 of a 5-word copy.
        for (int i = 0; i < 5; i++) begin
            load(16'h0100 + 16'(i), 16'hD000 + 16'(i));
            load(16'h0200 + 16'(i), 16'h0E00 + 16'(i));
        end
        ref_xfer(1'b0, 16'h0100, 16'h0200, 16'd2, 16'h0);   // only words 0-1 commit
        d0 = n_done;
        @(negedge clk);
        mode = 1'b0; src_addr = 16'h0100; dst_addr = 16'h0200; len = 16'd5; start = 1'b1;
        @(posedge clk);                                      // E0
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);                           // E5: WR of word 2
        #1;
        check("rst_mid.in_wr_word2", int'({mem_write_en, mem_access_addr}), 'h10202);
        reset = 1'b1;
        #1;
        check("rst_mid.outputs_zero",
              $countones({busy, done, words_done, mem_access_addr, mem_in,
                          mem_write_en, mem_read_en}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid.no_done", n_done - d0, 0);
        check("rst_mid.mem_image", image_mismatches(), 0);
        check("rst_mid.mem202_unwritten", int'(mem[16'h0202]), 'h0E02);

        rv = '{1'b1, 16'h0000, 16'h0203, 16'd2, 16'h4242, 2, 16'h0000, 0, 16'h0000};
        run_xfer(rv, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
